// File: rtl/ahb_arbiter_if.sv
// Arbitration signals between two AHB masters, the shared-bus muxes and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/bus side.
interface ahb_arbiter_if;
  logic       hbusreq_m0;
  logic       hbusreq_m1;
  logic       hlock_m0;
  logic       hlock_m1;
  logic [1:0] H_trans;
  logic [2:0] H_burst;
  logic       H_ready;
  logic       hgrant_m0;
  logic       hgrant_m1;
  logic       hmaster;
  logic       hmaster_d;
  logic       hmastlock;

  modport slave (
    input  hbusreq_m0, hbusreq_m1, hlock_m0, hlock_m1, H_trans, H_burst, H_ready,
    output hgrant_m0, hgrant_m1, hmaster, hmaster_d, hmastlock
  );

  modport master (
    output hbusreq_m0, hbusreq_m1, hlock_m0, hlock_m1, H_trans, H_burst, H_ready,
    input  hgrant_m0, hgrant_m1, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Two-master round-robin AHB arbiter; registered grants one cycle after a rearbitration edge.
// Wait states (H_ready=0) freeze ownership, lock and burst tracking; locked or mid-burst owners keep the bus.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  htrans_e          trans;
  logic [3:0]       beats_left;
  logic [3:0]       burst_len;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] pick;
  logic             burst_end;
  logic             rearb;
  logic             req_any;
  logic             lock_sel;

  assign trans = htrans_e'(bus.H_trans);

  always_comb begin
    burst_len = 4'd0;
    case (bus.H_burst)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  end

  // SEQ with a counter of 0 is an undefined-length INCR, so every beat may hand over.
  always_comb begin
    burst_end = 1'b0;
    case (trans)
      TR_IDLE:   burst_end = 1'b1;
      TR_NONSEQ: burst_end = (bus.H_burst == 3'b000) || (bus.H_burst == 3'b001);
      TR_SEQ:    burst_end = (beats_left <= 4'd1);
      default:   burst_end = 1'b0;
    endcase
  end

  assign rearb   = bus.H_ready && !bus.hmastlock && burst_end;
  assign req_any = bus.hbusreq_m0 || bus.hbusreq_m1;

  always_comb begin
    pick = DEF_IDX;
    case ({bus.hbusreq_m1, bus.hbusreq_m0})
      2'b11:   pick = ~last;
      2'b10:   pick = 1'b1;
      2'b01:   pick = 1'b0;
      default: pick = DEF_IDX;
    endcase
  end

  assign lock_sel = gnt_idx[0] ? bus.hlock_m1 : bus.hlock_m0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_idx       <= DEF_IDX;
      last          <= '0;
      beats_left    <= 4'd0;
      bus.hmaster   <= 1'b0;
      bus.hmaster_d <= 1'b0;
      bus.hmastlock <= 1'b0;
    end else begin
      if (rearb) begin
        gnt_idx <= pick;
        // Parking on the default master does not count as serving it.
        if (req_any && (pick != gnt_idx)) begin
          last <= pick;
        end
      end
      if (bus.H_ready) begin
        bus.hmastlock <= lock_sel;
        bus.hmaster   <= gnt_idx[0];
        bus.hmaster_d <= bus.hmaster;
        case (trans)
          TR_NONSEQ: beats_left <= burst_len;
          TR_SEQ:    if (beats_left != 4'd0) beats_left <= beats_left - 4'd1;
          TR_IDLE:   beats_left <= 4'd0;
          default:   beats_left <= beats_left;
        endcase
      end
    end
  end

  assign bus.hgrant_m0 = (gnt_idx == 1'b0);
  assign bus.hgrant_m1 = (gnt_idx == 1'b1);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a rule-level arbitration model.
module tb_ahb_arbiter;
  logic HCLK = 1'b0;
  logic HRESETn;

  ahb_arbiter_if bus ();

  ahb_arbiter #(
    .NUM_MASTERS    (2),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Reference state: who holds the grant, who was last served, burst beats remaining,
  // lock flag and the address/data phase owners.
  int m_gnt, m_last, m_beats, m_hm, m_hmd;
  int m_lock;
  int beats_tab [8] = '{0, 0, 3, 3, 7, 7, 15, 15};

  task automatic model_reset();
    m_gnt = 0; m_last = 0; m_beats = 0; m_hm = 0; m_hmd = 0; m_lock = 0;
  endtask

  task automatic model_update();
    int tr, bu, want;
    bit rearb, r0, r1;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    if (bus.H_ready !== 1'b1) return;
    tr = int'(bus.H_trans);
    bu = int'(bus.H_burst);
    r0 = bus.hbusreq_m0;
    r1 = bus.hbusreq_m1;
    rearb = (m_lock == 0) && (tr == 0 || (tr == 2 && bu < 2) || (tr == 3 && m_beats <= 1));
    m_lock = (m_gnt == 0) ? int'(bus.hlock_m0) : int'(bus.hlock_m1);
    m_hmd = m_hm;
    m_hm  = m_gnt;
    if (tr == 2) m_beats = beats_tab[bu];
    else if (tr == 3 && m_beats > 0) m_beats = m_beats - 1;
    else if (tr == 0) m_beats = 0;
    if (rearb) begin
      if (r0 && r1) want = 1 - m_last;
      else if (r1) want = 1;
      else if (r0) want = 0;
      else want = 0;
      if ((r0 || r1) && want != m_gnt) m_last = want;
      m_gnt = want;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hgrant_m0"}, bus.hgrant_m0, m_gnt == 0);
    chk({tag, ".hgrant_m1"}, bus.hgrant_m1, m_gnt == 1);
    chk({tag, ".hmaster"},   bus.hmaster,   m_hm[0]);
    chk({tag, ".hmaster_d"}, bus.hmaster_d, m_hmd[0]);
    chk({tag, ".hmastlock"}, bus.hmastlock, m_lock[0]);
  endtask

  task automatic drive(input bit r0, input bit r1, input bit l0, input bit l1,
                       input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
    bus.hbusreq_m0 = r0;
    bus.hbusreq_m1 = r1;
    bus.hlock_m0   = l0;
    bus.hlock_m1   = l1;
    bus.H_trans    = tr;
    bus.H_burst    = bu;
    bus.H_ready    = rdy;
  endtask

  task automatic step(input string tag);
    @(posedge HCLK);
    model_update();
    #1;
    check_all(tag);
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 3'b000, 1);
    model_reset();
    #3;
    check_all("reset");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single request from M1 on an idle bus.
    drive(0, 1, 0, 0, 2'b00, 3'b000, 1);
    step("single1"); chk("single_gnt_e1", bus.hgrant_m1, 1'b1);
    step("single2"); chk("single_hm_e2", bus.hmaster, 1'b1);
    step("single3"); chk("single_hmd_e3", bus.hmaster_d, 1'b1);

    // M1 INCR8 to beats_left=5, then asynchronous reset between edges.
    drive(0, 1, 0, 0, 2'b10, 3'b100, 1); step("incr8_ns");
    drive(0, 1, 0, 0, 2'b11, 3'b100, 1); step("incr8_s1");
    step("incr8_s2");
    #2;
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt0", bus.hgrant_m0, 1'b1);
    chk("arst_gnt1", bus.hgrant_m1, 1'b0);
    chk("arst_hm",   bus.hmaster,   1'b0);
    chk("arst_hmd",  bus.hmaster_d, 1'b0);
    chk("arst_lock", bus.hmastlock, 1'b0);
    drive(0, 0, 0, 0, 2'b00, 3'b000, 1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step("post_rst1");
    step("post_rst2"); chk("park_after_rst", bus.hgrant_m0, 1'b1);

    // Round robin with back-to-back SINGLE transfers.
    drive(1, 1, 0, 0, 2'b10, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      step("rr");
      chk("rr_alternate", bus.hgrant_m1, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // M0 INCR4 with two wait states on beat 2; M1 requests from the NONSEQ beat.
    drive(1, 1, 0, 0, 2'b10, 3'b011, 1); step("incr4_b1");
    chk("incr4_hold_b1", bus.hgrant_m1, 1'b0);
    drive(1, 1, 0, 0, 2'b11, 3'b011, 0);
    step("incr4_ws1"); chk("incr4_ws1_hmd", bus.hmaster_d, 1'b1);
    step("incr4_ws2"); chk("incr4_ws2_hmd", bus.hmaster_d, 1'b1);
    drive(1, 1, 0, 0, 2'b11, 3'b011, 1);
    step("incr4_b2"); chk("incr4_hold_b2", bus.hgrant_m1, 1'b0);
    step("incr4_b3"); chk("incr4_hold_b3", bus.hgrant_m1, 1'b0);
    step("incr4_b4"); chk("incr4_handover", bus.hgrant_m1, 1'b1);

    // Locked sequence from M0 while M1 keeps requesting.
    drive(1, 0, 1, 0, 2'b00, 3'b000, 1); step("lock_take");
    step("lock_set"); chk("lock_on", bus.hmastlock, 1'b1);
    drive(1, 1, 1, 0, 2'b10, 3'b000, 1);
    for (int i = 0; i < 3; i++) begin
      step("locked");
      chk("locked_gnt0", bus.hgrant_m0, 1'b1);
      chk("locked_flag", bus.hmastlock, 1'b1);
    end
    drive(0, 1, 0, 0, 2'b00, 3'b000, 1);
    step("unlock"); chk("unlock_no_switch", bus.hgrant_m1, 1'b0);
    step("unlock_rearb"); chk("unlock_gnt1", bus.hgrant_m1, 1'b1);

    // M1 INCR8 with BUSY cycles, then requests drop and the bus parks.
    drive(1, 1, 0, 0, 2'b10, 3'b100, 1); step("busy_ns");
    drive(1, 1, 0, 0, 2'b11, 3'b100, 1); step("busy_s1");
    drive(1, 1, 0, 0, 2'b01, 3'b100, 1);
    step("busy1"); chk("busy1_hold", bus.hgrant_m1, 1'b1);
    step("busy2"); chk("busy2_hold", bus.hgrant_m1, 1'b1);
    drive(1, 1, 0, 0, 2'b11, 3'b100, 1);
    for (int i = 0; i < 5; i++) step("busy_seq");
    chk("busy_burst_hold", bus.hgrant_m1, 1'b1);
    drive(0, 0, 0, 0, 2'b11, 3'b100, 1);
    step("park"); chk("park_gnt0", bus.hgrant_m0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0);
      step("rand");
      chk("onehot", bus.hgrant_m0 ^ bus.hgrant_m1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
